// File: rtl/sensor_poll_scheduler_pkg.sv
// Shared definitions for the sensor scheduler and the sensor-transaction executor.
package sensor_pkg;

    localparam int unsigned N_SENSORS = 32;
    localparam int unsigned N_SLOTS   = 64;
    localparam int unsigned SLOT_W    = 6;
    localparam int unsigned CNT_W     = 25;

    // Request codes; 3..6 control continuous monitoring, the rest go straight to the executor.
    localparam logic [7:0] CMD_0            = 8'd0;
    localparam logic [7:0] CMD_1            = 8'd1;
    localparam logic [7:0] CMD_2            = 8'd2;
    localparam logic [7:0] CMD_MON_TEMP_ON  = 8'd3;
    localparam logic [7:0] CMD_MON_HUM_ON   = 8'd4;
    localparam logic [7:0] CMD_MON_TEMP_OFF = 8'd5;
    localparam logic [7:0] CMD_MON_HUM_OFF  = 8'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } sched_state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
    } req_t;

    function automatic logic addr_valid(input logic [7:0] a);
        return a < 8'(N_SENSORS);
    endfunction

endpackage

// File: rtl/sensor_poll_scheduler_if.sv
// Request / executor handshake bundle between UART decoder, scheduler and executor.
interface sensor_poll_if;
    import sensor_pkg::*;

    logic                 new_data;
    logic [7:0]           command;
    logic [7:0]           address;
    logic                 exec_done;
    logic                 start;
    logic [7:0]           exec_command;
    logic [7:0]           exec_address;
    logic [N_SENSORS-1:0] temp_mask;
    logic [N_SENSORS-1:0] hum_mask;
    logic                 reject;
    logic                 timeout;

    modport master (
        output new_data, command, address, exec_done,
        input  start, exec_command, exec_address, temp_mask, hum_mask, reject, timeout
    );

    modport slave (
        input  new_data, command, address, exec_done,
        output start, exec_command, exec_address, temp_mask, hum_mask, reject, timeout
    );
endinterface

// File: rtl/sensor_poll_scheduler_rr_pick.sv
// Round-robin picker over the 64 monitoring slots: first set bit after ptr, wrapping.
module rr_pick
    import sensor_pkg::*;
(
    input  logic [N_SLOTS-1:0] req,
    input  logic [SLOT_W-1:0]  ptr,
    output logic               grant_valid,
    output logic [SLOT_W-1:0]  grant_slot
);

    logic [SLOT_W-1:0] idx;

    // Scan ptr+1 .. ptr+64 (mod 64); ptr itself is considered last.
    always_comb begin
        grant_valid = 1'b0;
        grant_slot  = '0;
        idx         = '0;
        for (int unsigned i = 1; i <= N_SLOTS; i++) begin
            idx = ptr + SLOT_W'(i);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_slot  = idx;
            end
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Arbitrates the single sensor-transaction engine between buffered one-shot
// requests and round-robin continuous polling, with timeout and recovery gap.
module sensor_poll_scheduler
    import sensor_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic         clock,
    input  logic         reset,
    sensor_poll_if.slave bus
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t         state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SLOT_W-1:0]    ptr_q;
    logic [N_SENSORS-1:0] temp_q, temp_d;
    logic [N_SENSORS-1:0] hum_q, hum_d;
    req_t                 buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 reject_q, reject_d;
    logic                 start_q, timeout_q;
    logic [7:0]           cmd_q, addr_q;
    logic                 consume, req_valid;
    logic                 grant_valid;
    logic [SLOT_W-1:0]    grant_slot;

    // The buffered one-shot is taken whenever the FSM sits in IDLE with it present.
    assign consume   = (state_q == ST_IDLE) && buf_full_q;
    assign req_valid = addr_valid(bus.address);

    rr_pick u_rr_pick (
        .req         ({hum_q, temp_q}),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_slot  (grant_slot)
    );

    // Request classification: mask updates, one-shot buffering, reject on overflow.
    always_comb begin
        temp_d     = temp_q;
        hum_d      = hum_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q && !consume;
        reject_d   = 1'b0;
        if (bus.new_data) begin
            if (buf_full_q && !consume) begin
                reject_d = 1'b1;
            end else if (req_valid && bus.command == CMD_MON_TEMP_ON) begin
                temp_d[bus.address[4:0]] = 1'b1;
            end else if (req_valid && bus.command == CMD_MON_HUM_ON) begin
                hum_d[bus.address[4:0]] = 1'b1;
            end else begin
                if (req_valid && bus.command == CMD_MON_TEMP_OFF) temp_d[bus.address[4:0]] = 1'b0;
                if (req_valid && bus.command == CMD_MON_HUM_OFF)  hum_d[bus.address[4:0]]  = 1'b0;
                buf_d      = '{cmd: bus.command, addr: bus.address};
                buf_full_d = 1'b1;
            end
        end
    end

    // Mask and buffer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            temp_q     <= '0;
            hum_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            temp_q     <= temp_d;
            hum_q      <= hum_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            reject_q   <= reject_d;
        end
    end

    // Transaction FSM with shared wait/gap counter and registered executor outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '1;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
        end else begin
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (buf_full_q) begin
                        cmd_q   <= buf_q.cmd;
                        addr_q  <= buf_q.addr;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else if (grant_valid) begin
                        cmd_q   <= grant_slot[5] ? CMD_MON_HUM_ON : CMD_MON_TEMP_ON;
                        addr_q  <= {3'b000, grant_slot[4:0]};
                        ptr_q   <= grant_slot;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.exec_done) begin
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.start        = start_q;
    assign bus.exec_command = cmd_q;
    assign bus.exec_address = addr_q;
    assign bus.temp_mask    = temp_q;
    assign bus.hum_mask     = hum_q;
    assign bus.reject       = reject_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Bench for sensor_poll_scheduler: directed request script followed by random
// requests and executor latencies, compared every cycle against a
// transaction-level reference model of the scheduling rules.
module tb_sensor_poll_scheduler;
    import sensor_pkg::*;

    localparam int GAP    = 20;
    localparam int TMO    = 150;
    localparam int NCYC   = 5000;
    localparam int RST_AT = 3000;
    localparam int ND     = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sensor_poll_if bus();

    sensor_poll_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    // Directed request script: edge at which new_data is sampled, command, address.
    int       d_edge [ND] = '{3, 300, 301, 430, 431, 432, 700, 800, 900, 1100, 1300, 1320};
    bit [7:0] d_cmd  [ND] = '{1, 3,   4,   0,   1,   2,   5,   6,   3,   9,    5,    2};
    bit [7:0] d_addr [ND] = '{5, 2,   7,   9,   1,   3,   2,   7,   2,   40,   2,    33};

    int n_checks = 0;
    int n_errors = 0;
    int cur_edge = 0;

    // Reference model state.
    bit [31:0] m_temp, m_hum;
    bit        m_buf_v;
    bit [7:0]  m_buf_cmd, m_buf_addr;
    int        m_ptr;
    bit        m_busy;
    int        m_s;
    int        m_free;
    bit [7:0]  m_cmd, m_addr;
    bit        e_start, e_reject, e_timeout;
    int        done_plan;

    // Driven stimulus for the upcoming edge.
    bit        d_nd, d_done;
    bit [7:0]  dr_cmd, dr_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d got %0h expected %0h", tag, cur_edge, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("start",        64'(bus.start),        64'(e_start));
        check_eq("exec_command", 64'(bus.exec_command), 64'(m_cmd));
        check_eq("exec_address", 64'(bus.exec_address), 64'(m_addr));
        check_eq("reject",       64'(bus.reject),       64'(e_reject));
        check_eq("timeout",      64'(bus.timeout),      64'(e_timeout));
        check_eq("temp_mask",    64'(bus.temp_mask),    64'(m_temp));
        check_eq("hum_mask",     64'(bus.hum_mask),     64'(m_hum));
    endtask

    task automatic model_reset();
        m_temp = '0; m_hum = '0;
        m_buf_v = 1'b0; m_buf_cmd = '0; m_buf_addr = '0;
        m_ptr = 63;
        m_busy = 1'b0; m_s = 0; m_free = 0;
        m_cmd = '0; m_addr = '0;
        e_start = 1'b0; e_reject = 1'b0; e_timeout = 1'b0;
        done_plan = -1;
    endtask

    // Executor reply time for a transaction started at edge s (-1: never replies).
    function automatic int pick_done(input int s);
        int r;
        if (s < 200)  return s + 100;
        if (s < 850)  return s + 30;
        if (s < 1400) return -1;
        r = int'($urandom_range(0, 11));
        if (r == 0) return -1;
        if (r == 1) return s + 1;
        if (r == 2) return s + 1 + TMO;
        return s + int'($urandom_range(2, 40));
    endfunction

    task automatic launch(input int e);
        m_busy    = 1'b1;
        m_s       = e;
        e_start   = 1'b1;
        done_plan = pick_done(e);
    endtask

    // One clock edge of the scheduling rules: a transaction started at edge s
    // is waiting on edges s+2 .. s+1+TMO; after it ends at edge E the next
    // selection may happen at edge E+GAP+1.
    task automatic model_step(input int e);
        int sl;
        e_start = 1'b0; e_reject = 1'b0; e_timeout = 1'b0;
        if (m_busy) begin
            if (d_done && e >= m_s + 2) begin
                m_busy = 1'b0;
                m_free = e + GAP + 1;
            end else if (e == m_s + 1 + TMO) begin
                m_busy    = 1'b0;
                e_timeout = 1'b1;
                m_free    = e + GAP + 1;
            end
        end else if (e >= m_free) begin
            if (m_buf_v) begin
                m_cmd   = m_buf_cmd;
                m_addr  = m_buf_addr;
                m_buf_v = 1'b0;
                launch(e);
            end else begin
                for (int k = 1; k <= 64; k++) begin
                    sl = (m_ptr + k) % 64;
                    if ((sl < 32) ? m_temp[sl] : m_hum[sl - 32]) begin
                        m_cmd  = (sl < 32) ? 8'd3 : 8'd4;
                        m_addr = 8'(sl % 32);
                        m_ptr  = sl;
                        launch(e);
                        break;
                    end
                end
            end
        end
        if (d_nd) begin
            if (m_buf_v) begin
                e_reject = 1'b1;
            end else if (dr_addr < 32 && dr_cmd == 3) begin
                m_temp[dr_addr[4:0]] = 1'b1;
            end else if (dr_addr < 32 && dr_cmd == 4) begin
                m_hum[dr_addr[4:0]] = 1'b1;
            end else begin
                if (dr_addr < 32 && dr_cmd == 5) m_temp[dr_addr[4:0]] = 1'b0;
                if (dr_addr < 32 && dr_cmd == 6) m_hum[dr_addr[4:0]]  = 1'b0;
                m_buf_v    = 1'b1;
                m_buf_cmd  = dr_cmd;
                m_buf_addr = dr_addr;
            end
        end
    endtask

    task automatic drive(input int e);
        int r;
        d_nd = 1'b0; dr_cmd = 8'($urandom_range(0, 255)); dr_addr = 8'($urandom_range(0, 255));
        d_done = 1'b0;
        if (!reset) begin
            for (int i = 0; i < ND; i++) begin
                if (d_edge[i] == e) begin
                    d_nd = 1'b1; dr_cmd = d_cmd[i]; dr_addr = d_addr[i];
                end
            end
            if (e > 1500 && $urandom_range(0, 19) == 0) begin
                r = int'($urandom_range(0, 9));
                d_nd    = 1'b1;
                dr_cmd  = (r < 7) ? 8'(r) : ((r == 7) ? 8'd9 : 8'($urandom_range(0, 255)));
                dr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 255))
                                                      : 8'($urandom_range(0, 31));
            end
            d_done = (e == done_plan) || (e == RST_AT + 6)
                     || (e > 1500 && $urandom_range(0, 99) == 0);
        end
        bus.new_data  = d_nd;
        bus.command   = dr_cmd;
        bus.address   = dr_addr;
        bus.exec_done = d_done;
    endtask

    initial begin
        bus.new_data = 1'b0; bus.command = '0; bus.address = '0; bus.exec_done = 1'b0;
        model_reset();
        #5;
        check_all();
        for (int e = 1; e <= NCYC; e++) begin
            @(negedge clock);
            cur_edge = e;
            reset = (e >= RST_AT && e < RST_AT + 4);
            drive(e);
            if (reset) begin
                // Asynchronous reset must clear outputs before any clock edge.
                #1;
                model_reset();
                check_all();
                @(posedge clock);
                #1;
                check_all();
            end else begin
                @(posedge clock);
                model_step(e);
                #1;
                check_all();
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
